// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction fetch FSM with registered outputs (optional macro FETCH_MISALIGN_CHECK_EN)
module instruction_fetch #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] pc_next,
    input  logic                  fetch_start,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic                  misaligned,
`endif
    output logic                  busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] VALID = 2'd3;
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, launch_addr;
    logic                  discard_q, discard_d;
    logic                  mem_req_q, instr_valid_q, busy_q;
    logic [DATA_WIDTH-1:0] mem_addr_q, instr_q, instr_d, instr_pc_q, instr_pc_d;
    logic                  launch, mis;

    assign launch_addr = fetch_start ? pc_next : addr_q;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_q;
    assign mis        = launch_addr[1:0] != 2'b00;
    assign misaligned = misaligned_q;
`else
    assign mis = 1'b0;
`endif

    // Next state: a granted request is never re-issued until its response has been consumed or dropped
    always_comb begin
        state_d    = state_q;
        discard_d  = discard_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        launch     = 1'b0;
        if (fetch_start) begin
            if (state_q == WAIT && !mem_rvalid) begin
                discard_d = 1'b1;
            end else if (state_q == REQ && mem_gnt) begin
                state_d   = WAIT;
                discard_d = 1'b1;
            end else begin
                launch    = 1'b1;
                discard_d = 1'b0;
            end
        end else if (state_q == REQ && mem_gnt) begin
            state_d = WAIT;
        end else if (state_q == WAIT && mem_rvalid) begin
            if (discard_q) begin
                launch    = 1'b1;
                discard_d = 1'b0;
            end else begin
                state_d    = VALID;
                instr_d    = mem_rdata;
                instr_pc_d = addr_q;
            end
        end else if (state_q == VALID && instr_ready) begin
            state_d = IDLE;
        end
        if (launch) begin
            state_d = mis ? VALID : REQ;
        end
        if (launch && mis) begin
            instr_d    = NOP;
            instr_pc_d = launch_addr;
        end
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            discard_q     <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= launch_addr;
            discard_q     <= discard_d;
            mem_req_q     <= state_d == REQ;
            mem_addr_q    <= state_d == REQ ? {launch_addr[DATA_WIDTH-1:2], 2'b00} : '0;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= state_d == VALID;
            busy_q        <= state_d != IDLE;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned flag rises with a misaligned launch and lasts while that word is presented
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= (launch && mis) || (misaligned_q && state_d == VALID);
        end
    end
`endif

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and randomized checks of instruction_fetch against a transaction-level model
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc_next = '0;
    logic        fetch_start = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        busy;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misaligned;
`endif
    int checks = 0;
    int errors = 0;

    instruction_fetch #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .pc_next(pc_next), .fetch_start(fetch_start),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready),
`ifdef FETCH_MISALIGN_CHECK_EN
        .misaligned(misaligned),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_pc();
`ifdef FETCH_MISALIGN_CHECK_EN
        return $urandom & 32'hFFFF_FFFC;
`else
        return $urandom;
`endif
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++; if ({mem_req, instr_valid, busy} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b exp 000", {mem_req, instr_valid, busy}); end
        checks++; if ({mem_addr, instr, instr_pc} !== 96'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {mem_addr, instr, instr_pc}); end
`ifdef FETCH_MISALIGN_CHECK_EN
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %b exp 0", misaligned); end
`endif
        reset_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle got %b exp 0", busy); end
    endtask

    task automatic test_basic();
        fetch_start = 1'b1; pc_next = 32'h100; step(); fetch_start = 1'b0;
        checks++; if ({mem_req, busy, instr_valid} !== 3'b110) begin errors++; $display("FAIL basic_req got %b exp 110", {mem_req, busy, instr_valid}); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL basic_addr got %h exp 100", mem_addr); end
        mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
        checks++; if ({mem_req, instr_valid, busy} !== 3'b001) begin errors++; $display("FAIL basic_wait got %b exp 001", {mem_req, instr_valid, busy}); end
        mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093; step(); mem_rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", instr_valid); end
        checks++; if ({instr, instr_pc} !== {32'h0050_0093, 32'h100}) begin errors++; $display("FAIL basic_instr got %h exp %h", {instr, instr_pc}, {32'h0050_0093, 32'h100}); end
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        checks++; if ({instr_valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_done got %b exp 00", {instr_valid, busy}); end
    endtask

    task automatic test_stalls();
        fetch_start = 1'b1; pc_next = 32'h100; step(); fetch_start = 1'b0;
        repeat (3) begin
            checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL gnt_stall got %h exp %h", {mem_req, mem_addr}, {1'b1, 32'h100}); end
            step();
        end
        checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL gnt_hold got %h exp %h", {mem_req, mem_addr}, {1'b1, 32'h100}); end
        mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
        checks++; if ({mem_req, busy} !== 2'b01) begin errors++; $display("FAIL gnt_wait got %b exp 01", {mem_req, busy}); end
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; step(); mem_rvalid = 1'b0;
        repeat (4) begin
            checks++; if ({instr_valid, instr} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL ready_stall got %h exp %h", {instr_valid, instr}, {1'b1, 32'h1234_5678}); end
            step();
        end
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        checks++; if ({instr_valid, busy} !== 2'b00) begin errors++; $display("FAIL ready_done got %b exp 00", {instr_valid, busy}); end
    endtask

    task automatic test_discard();
        fetch_start = 1'b1; pc_next = 32'h100; step(); fetch_start = 1'b0;
        mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
        fetch_start = 1'b1; pc_next = 32'h200; step(); fetch_start = 1'b0;
        checks++; if ({mem_req, instr_valid, busy} !== 3'b001) begin errors++; $display("FAIL disc_wait got %b exp 001", {mem_req, instr_valid, busy}); end
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; step(); mem_rvalid = 1'b0;
        checks++; if ({instr_valid, mem_req, mem_addr} !== {2'b01, 32'h200}) begin errors++; $display("FAIL disc_drop got %h exp %h", {instr_valid, mem_req, mem_addr}, {2'b01, 32'h200}); end
        mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013; step(); mem_rvalid = 1'b0;
        checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h13, 32'h200}) begin errors++; $display("FAIL disc_refetch got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, 32'h13, 32'h200}); end
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
    endtask

    task automatic test_restart();
        fetch_start = 1'b1; pc_next = 32'h300; step();
        pc_next = 32'h304; mem_gnt = 1'b1; step(); fetch_start = 1'b0; mem_gnt = 1'b0;
        checks++; if ({mem_req, busy} !== 2'b01) begin errors++; $display("FAIL req_restart got %b exp 01", {mem_req, busy}); end
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0001; step(); mem_rvalid = 1'b0;
        checks++; if ({instr_valid, mem_req, mem_addr} !== {2'b01, 32'h304}) begin errors++; $display("FAIL req_reissue got %h exp %h", {instr_valid, mem_req, mem_addr}, {2'b01, 32'h304}); end
        mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
        fetch_start = 1'b1; pc_next = 32'h604; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0002; step();
        fetch_start = 1'b0; mem_rvalid = 1'b0;
        checks++; if ({instr_valid, mem_req, mem_addr} !== {2'b01, 32'h604}) begin errors++; $display("FAIL same_cycle got %h exp %h", {instr_valid, mem_req, mem_addr}, {2'b01, 32'h604}); end
        mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055; step(); mem_rvalid = 1'b0;
        checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h55, 32'h604}) begin errors++; $display("FAIL same_instr got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, 32'h55, 32'h604}); end
        fetch_start = 1'b1; pc_next = 32'h500; instr_ready = 1'b1; step(); fetch_start = 1'b0; instr_ready = 1'b0;
        checks++; if ({instr_valid, mem_req, mem_addr} !== {2'b01, 32'h500}) begin errors++; $display("FAIL valid_restart got %h exp %h", {instr_valid, mem_req, mem_addr}, {2'b01, 32'h500}); end
        mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077; step(); mem_rvalid = 1'b0;
        checks++; if ({instr_valid, instr_pc} !== {1'b1, 32'h500}) begin errors++; $display("FAIL valid_refetch got %h exp %h", {instr_valid, instr_pc}, {1'b1, 32'h500}); end
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        fetch_start = 1'b1; pc_next = 32'h100; step(); fetch_start = 1'b0;
        mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
        reset_n = 1'b0; step(); reset_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; step(); mem_rvalid = 1'b0;
        checks++; if ({mem_req, instr_valid, busy} !== 3'b000) begin errors++; $display("FAIL rst_mid_ctrl got %b exp 000", {mem_req, instr_valid, busy}); end
        checks++; if ({mem_addr, instr, instr_pc} !== 96'h0) begin errors++; $display("FAIL rst_mid_data got %h exp 0", {mem_addr, instr, instr_pc}); end
        step();
        checks++; if ({instr_valid, busy} !== 2'b00) begin errors++; $display("FAIL rst_mid_idle got %b exp 00", {instr_valid, busy}); end
    endtask

`ifdef FETCH_MISALIGN_CHECK_EN
    task automatic test_misalign();
        fetch_start = 1'b1; pc_next = 32'h102; step(); fetch_start = 1'b0;
        checks++; if ({mem_req, instr_valid, misaligned} !== 3'b011) begin errors++; $display("FAIL mis_ctrl got %b exp 011", {mem_req, instr_valid, misaligned}); end
        checks++; if ({instr, instr_pc} !== {32'h13, 32'h102}) begin errors++; $display("FAIL mis_data got %h exp %h", {instr, instr_pc}, {32'h13, 32'h102}); end
        step();
        checks++; if ({mem_req, instr_valid, misaligned} !== 3'b011) begin errors++; $display("FAIL mis_hold got %b exp 011", {mem_req, instr_valid, misaligned}); end
        instr_ready = 1'b1; step(); instr_ready = 1'b0;
        checks++; if ({instr_valid, misaligned, busy} !== 3'b000) begin errors++; $display("FAIL mis_done got %b exp 000", {instr_valid, misaligned, busy}); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] cur, nxt, data;
        int mode;
        for (int t = 0; t < 40; t++) begin
            cur = rnd_pc();
            data = $urandom;
            fetch_start = 1'b1; pc_next = cur; step(); fetch_start = 1'b0;
            for (int a = 0; a < 3; a++) begin
                repeat ($urandom_range(0, 3)) begin
                    checks++; if ({mem_req, mem_addr} !== {1'b1, cur & 32'hFFFF_FFFC}) begin errors++; $display("FAIL rnd_req got %h exp %h", {mem_req, mem_addr}, {1'b1, cur & 32'hFFFF_FFFC}); end
                    step();
                end
                checks++; if ({mem_req, mem_addr} !== {1'b1, cur & 32'hFFFF_FFFC}) begin errors++; $display("FAIL rnd_gnt got %h exp %h", {mem_req, mem_addr}, {1'b1, cur & 32'hFFFF_FFFC}); end
                mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    checks++; if ({mem_req, instr_valid, busy} !== 3'b001) begin errors++; $display("FAIL rnd_wait got %b exp 001", {mem_req, instr_valid, busy}); end
                    step();
                end
                mode = (a < 2) ? int'($urandom_range(0, 3)) : 3;
                nxt = rnd_pc();
                if (mode == 0) begin
                    fetch_start = 1'b1; pc_next = nxt; step(); fetch_start = 1'b0;
                    checks++; if ({mem_req, instr_valid} !== 2'b00) begin errors++; $display("FAIL rnd_abort got %b exp 00", {mem_req, instr_valid}); end
                    mem_rvalid = 1'b1; mem_rdata = $urandom; step(); mem_rvalid = 1'b0;
                    cur = nxt;
                end else if (mode == 1) begin
                    fetch_start = 1'b1; pc_next = nxt; mem_rvalid = 1'b1; mem_rdata = $urandom; step();
                    fetch_start = 1'b0; mem_rvalid = 1'b0;
                    cur = nxt;
                end else begin
                    mem_rvalid = 1'b1; mem_rdata = data; step(); mem_rvalid = 1'b0;
                    break;
                end
            end
            checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, data, cur}) begin errors++; $display("FAIL rnd_instr got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, data, cur}); end
            repeat ($urandom_range(0, 2)) begin
                step();
                checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, data, cur}) begin errors++; $display("FAIL rnd_hold got %h exp %h", {instr_valid, instr, instr_pc}, {1'b1, data, cur}); end
            end
            instr_ready = 1'b1; step(); instr_ready = 1'b0;
            checks++; if ({instr_valid, busy, mem_req} !== 3'b000) begin errors++; $display("FAIL rnd_done got %b exp 000", {instr_valid, busy, mem_req}); end
            if ($urandom_range(0, 1) == 1) begin
                mem_rvalid = 1'b1; mem_rdata = $urandom; step(); mem_rvalid = 1'b0;
                checks++; if ({instr_valid, busy} !== 2'b00) begin errors++; $display("FAIL rnd_stray got %b exp 00", {instr_valid, busy}); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_discard();
        test_restart();
        test_reset_mid();
`ifdef FETCH_MISALIGN_CHECK_EN
        test_misalign();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
